mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if -- bundle of the request, memory and pipeline-stall
// signals around the shared memory port arbiter.
//
//   fetch port : f_req, f_addr                         (requester -> arbiter)
//   data port  : d_req, d_we, d_addr, d_wdata          (requester -> arbiter)
//   memory     : mem_ready, mem_rdata                  (memory -> arbiter)
//                mem_req, mem_we, mem_addr, mem_wdata  (arbiter -> memory)
//   status     : mux_sel, f_ack, d_ack, rdata, f_stall, d_stall (arbiter -> pipeline)
//
// The slave modport is the arbiter's view; master is the surrounding
// pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] d_wdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mux_sel;
    logic              f_ack;
    logic              d_ack;
    logic [ADDR_W-1:0] rdata;
    logic              f_stall;
    logic              d_stall;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mux_sel, f_ack, d_ack, rdata,
               f_stall, d_stall
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mux_sel, f_ack, d_ack, rdata,
               f_stall, d_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port between an instruction-fetch
// requester and a data requester.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (request ports, memory side, stalls)
//
// Data normally wins arbitration. A starvation counter counts data
// completions while fetch is waiting; once it reaches STARVE_LIM the fetch
// port is granted next. Operands are latched on every grant so the memory
// sees stable values while mem_ready is low, whatever the requesters do.
// At a fetch completion the fetch request that was just served is not
// reconsidered; at a data completion a still-high d_req is a new back-to-back
// data request, which is what lets the starvation limit come into play (a
// data requester with nothing further to do drops d_req in its ack cycle).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_LIM = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic [ADDR_W-1:0] f_addr_reg;
    logic [ADDR_W-1:0] d_addr_reg;
    logic [ADDR_W-1:0] d_wdata_reg;
    logic              d_we_reg;
    logic              done;
    logic              load;
    logic              f_cand;

    // current access finishes this cycle; mem_ready means nothing in IDLE
    assign done = (state_reg != IDLE) && bus.mem_ready;
    // a grant decision is made whenever the port is free or being freed
    assign load = (state_reg == IDLE) || done;

    // state register, starvation counter and latched operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            f_addr_reg     <= '0;
            d_addr_reg     <= '0;
            d_wdata_reg    <= '0;
            d_we_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            if (load && (state_next == DATA)) begin
                d_addr_reg  <= bus.d_addr;
                d_wdata_reg <= bus.d_wdata;
                d_we_reg    <= bus.d_we;
            end
            if (load && (state_next == FETCH)) begin
                f_addr_reg <= bus.f_addr;
            end
        end
    end

    // starvation counter: only meaningful while fetch is actually waiting
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!bus.f_req || ((state_reg == FETCH) && done)) begin
            starve_cnt_next = '0;
        end else if ((state_reg == DATA) && done && (starve_cnt_reg != LIM)) begin
            starve_cnt_next = starve_cnt_reg + CNT_W'(1);
        end
    end

    // next state; arbitration uses the counter value including this cycle's
    // data completion, so exactly STARVE_LIM data grants pass a waiting fetch
    always_comb begin
        state_next = state_reg;
        f_cand     = bus.f_req && (state_reg != FETCH);
        if (load) begin
            if (bus.d_req && !(f_cand && (starve_cnt_next == LIM))) begin
                state_next = DATA;
            end else if (f_cand) begin
                state_next = FETCH;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // outputs: decoded from the registered state only, no request-to-mem_req path
    always_comb begin
        bus.mem_req   = (state_reg != IDLE);
        bus.mux_sel   = (state_reg == DATA);
        bus.mem_addr  = (state_reg == DATA) ? d_addr_reg : f_addr_reg;
        bus.mem_we    = (state_reg == DATA) && d_we_reg;
        bus.mem_wdata = d_wdata_reg;
        bus.f_ack     = (state_reg == FETCH) && bus.mem_ready;
        bus.d_ack     = (state_reg == DATA) && bus.mem_ready;
        bus.rdata     = bus.mem_rdata;
        bus.f_stall   = bus.f_req && !((state_reg == FETCH) && bus.mem_ready);
        bus.d_stall   = bus.d_req && !((state_reg == DATA) && bus.mem_ready);
    end
endmodule
